// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_pkg
//  Purpose  : Shared types and constants for the FIFO-fed UART transmitter.
//             Holds the transmitter state encoding, frame-level constants
//             and a small parity helper used when parity is built in.
//  Revision : 1.0  - initial release
// ============================================================================
package fifo_uart_pkg;

    // Transmitter sequencing states. PARITY is only ever entered when the
    // parity option is compiled in; otherwise it is an unused encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Even parity: the parity bit makes the total count of ones even,
    // which is simply the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage : fifo_uart_pkg
`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Bit-period timer for the UART transmitter. Counts
//             0..CLKS_PER_BIT-1 and flags the last cycle of every serial bit.
//  Ports    : clock     - system clock, rising edge
//             reset     - asynchronous reset, active-high
//             clear     - holds the counter at zero (transmitter not framing)
//             bit_done  - high on the last cycle of the current bit period
//  Revision : 1.0  - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    // Guard the width so a degenerate parameter still elaborates cleanly.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == C_LAST_COUNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || w_at_last) begin
            // Wrapping on the last cycle makes every bit boundary a clear.
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Masked by clear so no spurious boundary is reported while held idle.
    assign bit_done = w_at_last && !clear;

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : UART transmitter that drains the upstream 8-bit FIFO. Pops one
//             byte per frame through an active-low read strobe and
//             serialises it as start bit, 8 data bits LSB first, optional
//             even parity and one stop bit.
//  Config   : `UART_TX_PARITY_EN - when defined, an even-parity bit is
//             inserted between the last data bit and the stop bit.
//  Ports    : clock       - system clock, rising edge
//             reset       - asynchronous reset, active-high
//             enable      - permits new frames to start
//             fifo_empty  - FIFO empty flag
//             fifo_data   - FIFO read data, valid the cycle after the strobe
//             fifo_read_n - FIFO read strobe, active-low, one cycle per byte
//             tx          - serial output, idles high
//             busy        - high while a byte is fetched or transmitted
//  Revision : 1.0  - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_read_n,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [2:0] C_LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic                 r_tx;
    logic                 r_read_n;
    logic                 r_busy;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_bit_done;
    logic w_baud_clear;
    logic w_can_start;

    // The bit timer only runs while a frame is on the line; it sits at zero
    // through IDLE/FETCH/LOAD so the start bit always gets a full period.
    assign w_baud_clear = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

    // The only two places a new frame may be launched evaluate this.
    assign w_can_start = enable && !fifo_empty;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_baud_clear),
        .bit_done (w_bit_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= STOP_LEVEL;
            r_read_n  <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_can_start) begin
                        r_state  <= FETCH;
                        r_read_n <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end

                FETCH: begin
                    // Strobe is a single cycle; the FIFO presents data next.
                    r_read_n <= 1'b1;
                    r_state  <= LOAD;
                end

                LOAD: begin
                    r_shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
                    r_parity <= even_parity(fifo_data);
`endif
                    r_tx    <= START_LEVEL;
                    r_state <= START;
                end

                START: begin
                    if (w_bit_done) begin
                        // Present bit 0 and pre-shift so r_shift[0] is
                        // always the next bit to go out.
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_done) begin
                        // Wraps 7 -> 0 on exit, ready for the next frame.
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= STOP_LEVEL;
                            r_state <= STOP;
`endif
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_done) begin
                        r_tx    <= STOP_LEVEL;
                        r_state <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_done) begin
                        // Chaining straight into FETCH gives the minimum
                        // two-cycle high gap (FETCH, LOAD) between frames.
                        if (w_can_start) begin
                            r_state  <= FETCH;
                            r_read_n <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean idle line.
                    r_state  <= IDLE;
                    r_tx     <= STOP_LEVEL;
                    r_read_n <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign tx          = r_tx;
    assign fifo_read_n = r_read_n;
    assign busy        = r_busy;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Purpose  : Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4.
//             Table of known bytes with hand-derived frames, hand-written
//             reset / enable sequences, and randomised bytes checked against
//             a slot-level frame model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FRAME_CYCLES = SLOTS * CPB;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_read_n;
    logic       tx;
    logic       busy;

    // Upstream FIFO model: registered read, data valid after the strobe.
    logic [7:0] mem [0:255];
    int         wr_ptr     = 0;
    int         rd_ptr     = 0;
    int         underflows = 0;

    int vectors     = 0;
    int miscompares = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clock = ~clock;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_n (fifo_read_n),
        .tx          (tx),
        .busy        (busy)
    );

    always @(posedge clock) begin
        if (fifo_read_n === 1'b0) begin
            if (wr_ptr == rd_ptr) begin
                underflows <= underflows + 1;
            end else begin
                fifo_data <= mem[rd_ptr[7:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required finish before)", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, d7..d0, start}, slot 0 in bit 0
        logic       par;     // expected even parity bit
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Line level per bit slot, from the frame definition.
    function automatic logic [10:0] model_slots(input logic [7:0] b);
        logic [10:0] s;
        s = '1;
        s[0] = 1'b0;
        for (int k = 0; k < 8; k++) s[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
        s[9] = ^b;
`endif
        return s;
    endfunction

    function automatic logic [10:0] tbl_slots(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b1, v.frame};
`endif
    endfunction

    // Waits (bounded) for the read strobe, then checks every cycle of
    // FETCH, LOAD and the whole frame. Ends on the negedge after STOP.
    task automatic run_frame(input logic [10:0] slots, input int exp_wait,
                             input bit scramble, input string tag);
        int         waited;
        logic       lvl;
        logic [2:0] exp;
        waited = 0;
        while (fifo_read_n !== 1'b0 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        chk({tag, " strobe_wait"}, waited, exp_wait);
        if (fifo_read_n !== 1'b0) return;
        for (int c = 0; c < 2 + FRAME_CYCLES; c++) begin
            lvl = (c < 2) ? 1'b1 : slots[(c-2)/CPB];
            exp = {lvl, 1'b1, (c == 0) ? 1'b0 : 1'b1};
            chk($sformatf("%s cyc%0d {tx,busy,rd_n}", tag, c),
                {29'd0, tx, busy, fifo_read_n}, {29'd0, exp});
            if (scramble)
                enable = (c == 1 + FRAME_CYCLES) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clock);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle {tx,busy,rd_n}"}, {29'd0, tx, busy, fifo_read_n}, 32'd5);
    endtask

    initial begin
        logic [7:0] grp [$];
        int         waited;
        int         n;

        tbl[0] = '{8'hA5, 10'h34A, 1'b0};
        tbl[1] = '{8'h00, 10'h200, 1'b0};
        tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
        tbl[3] = '{8'h07, 10'h20E, 1'b1};
        tbl[4] = '{8'h5A, 10'h2B4, 1'b0};
        tbl[5] = '{8'h80, 10'h300, 1'b1};
        tbl[6] = '{8'h01, 10'h202, 1'b1};

        // Reset takes effect without a clock edge.
        #2 reset = 1'b1;
        #1 chk("reset_async {tx,busy,rd_n}", {29'd0, tx, busy, fifo_read_n}, 32'd5);
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        enable = 1'b1;
        check_idle("post_reset");

        // Single byte.
        push(tbl[0].data);
        run_frame(tbl_slots(tbl[0]), 1, 1'b0, "single_A5");
        check_idle("after_single");

        // Back-to-back frames from a pre-filled FIFO.
        for (int i = 1; i < 7; i++) push(tbl[i].data);
        for (int i = 1; i < 7; i++)
            run_frame(tbl_slots(tbl[i]), (i == 1) ? 1 : 0, 1'b0, $sformatf("tbl%0d", i));
        check_idle("after_table");

        // enable low holds off a non-empty FIFO.
        enable = 1'b0;
        push(8'h3C);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk($sformatf("enable_low cyc%0d {busy,rd_n}", i), {30'd0, busy, fifo_read_n}, 32'd1);
        end
        enable = 1'b1;
        run_frame(model_slots(8'h3C), 1, 1'b0, "enable_rise");
        check_idle("after_enable");

        // Reset during data bit 3 of 0x5A; the next byte goes out intact.
        push(8'h5A);
        push(8'hC3);
        waited = 0;
        while (fifo_read_n !== 1'b0 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        chk("midreset strobe_wait", waited, 1);
        repeat (19) @(negedge clock);
        chk("midreset bit3 tx", {31'd0, tx}, {31'd0, model_slots(8'h5A)[4]});
        #1 reset = 1'b1;
        #1 chk("midreset async {tx,busy,rd_n}", {29'd0, tx, busy, fifo_read_n}, 32'd5);
        @(negedge clock);
        reset = 1'b0;
        run_frame(model_slots(8'hC3), 1, 1'b0, "post_midreset");
        check_idle("after_midreset");

        // Random bytes in bursts, enable toggled mid-frame.
        for (int g = 0; g < 8; g++) begin
            repeat ($urandom_range(0, 5)) @(negedge clock);
            n = $urandom_range(1, 3);
            grp.delete();
            for (int j = 0; j < n; j++) begin
                grp.push_back(8'($urandom_range(0, 255)));
                push(grp[j]);
            end
            for (int j = 0; j < n; j++)
                run_frame(model_slots(grp[j]), (j == 0) ? 1 : 0, 1'b1,
                          $sformatf("rand g%0d b%0d %02h", g, j, grp[j]));
            check_idle($sformatf("rand g%0d end", g));
        end

        chk("reads_while_empty", underflows, 0);
        chk("bytes_consumed", rd_ptr, wr_ptr);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire
